// File: rtl/memory_access_if.sv
// ---------------------------------------------------------------------------
// memory_access_if
//
// Data-memory port of the memory stage. The stage is the master (drives the
// request side), the data memory is the slave (accepts requests and returns
// load data).
//
// Handshake:
//   - A request is the set {dmem_we, dmem_addr, dmem_wdata, dmem_wstrb}
//     qualified by dmem_req. Once dmem_req is high, the master holds it and
//     the request fields stable until the cycle in which dmem_ready is also
//     high. That cycle is the transfer. dmem_ready seen while dmem_req is
//     low means nothing.
//   - Stores are complete at the transfer.
//   - A load transfer is answered later by exactly one cycle with
//     dmem_rvalid high, carrying the whole aligned doubleword on dmem_rdata.
//     The master is always able to take that data, so there is no back-pressure.
//
// Signals:
//   dmem_req     master->slave  request present
//   dmem_we      master->slave  1 = store, 0 = load
//   dmem_addr    master->slave  doubleword-aligned byte address
//   dmem_wdata   master->slave  store data already shifted into its byte lanes
//   dmem_wstrb   master->slave  byte enables for the store
//   dmem_ready   slave->master  request accepted this cycle
//   dmem_rvalid  slave->master  load data valid this cycle
//   dmem_rdata   slave->master  load data (full doubleword)
// ---------------------------------------------------------------------------
interface memory_access_if #(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
);
  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [STRB_W-1:0] dmem_wstrb;
  logic              dmem_ready;
  logic              dmem_rvalid;
  logic [XLEN-1:0]   dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_wstrb,
    input  dmem_ready,
    input  dmem_rvalid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_wstrb,
    output dmem_ready,
    output dmem_rvalid,
    output dmem_rdata
  );
endinterface

// File: rtl/memory_access.sv
// ---------------------------------------------------------------------------
// memory_access
//
// Memory (M) stage of the 64-bit RISC-V pipeline, directly upstream of
// write-back. Non-memory instructions pass straight through to the W
// registers in one cycle. Loads and stores are issued as aligned doubleword
// requests on the data-memory port; load data is lane-selected and sign- or
// zero-extended before being registered. While a memory access is in flight
// the stage stalls upstream and sends bubbles to write-back.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   valid_m               instruction present in M
//   alu_result_m          ALU result / effective address
//   write_data_m          store data (rs2)
//   next_instruction_m    PC+4
//   result_src_m          0 = ALU, 1 = memory, 2 = PC+4
//   mem_write_m           store
//   reg_write_m           register write enable
//   funct3_m              access size / signedness
//   rd_m                  destination register
//   stall_m               hold upstream stages (combinational)
//   dmem                  data-memory port (master side)
//   valid_w .. misaligned_w  registered W-stage outputs
//   state_dbg             current FSM state (IDLE=0, REQ=1, WAIT_DATA=2)
// ---------------------------------------------------------------------------
module memory_access #(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              valid_m,
  input  logic [XLEN-1:0]   alu_result_m,
  input  logic [XLEN-1:0]   write_data_m,
  input  logic [XLEN-1:0]   next_instruction_m,
  input  logic [1:0]        result_src_m,
  input  logic              mem_write_m,
  input  logic              reg_write_m,
  input  logic [2:0]        funct3_m,
  input  logic [4:0]        rd_m,

  output logic              stall_m,

  memory_access_if.master   dmem,

  output logic              valid_w,
  output logic [XLEN-1:0]   alu_result_w,
  output logic [XLEN-1:0]   mem_data_w,
  output logic [XLEN-1:0]   next_instruction_w,
  output logic [1:0]        result_src_w,
  output logic [4:0]        rd_w,
  output logic              reg_write_w,
  output logic              misaligned_w,

  output logic [1:0]        state_dbg
);

  // FSM encoding
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_REQ       = 2'd1;
  localparam logic [1:0] S_WAIT_DATA = 2'd2;

  localparam int OFF_W = $clog2(STRB_W);

  logic [1:0]        state;
  logic [1:0]        state_next;

  logic [OFF_W-1:0]  offset;
  logic              is_store;
  logic              is_load;
  logic              is_mem;
  logic              is_alu;
  logic              legal_f3;
  logic              aligned;
  logic              misaligned;
  logic              mem_go;

  logic              req;
  logic              accept;
  logic              store_done;
  logic              load_done;

  logic [STRB_W-1:0] size_mask;
  logic [XLEN-1:0]   lane;
  logic [XLEN-1:0]   load_data;

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  assign offset   = alu_result_m[OFF_W-1:0];

  // A store wins over result_src; result_src only marks a load when it is
  // not a store.
  assign is_store = valid_m & mem_write_m;
  assign is_load  = valid_m & ~mem_write_m & (result_src_m == 2'd1);
  assign is_mem   = is_store | is_load;
  assign is_alu   = valid_m & ~is_mem;

  always_comb begin
    legal_f3 = 1'b0;
    if (is_store) legal_f3 = ~funct3_m[2];
    else          legal_f3 = (funct3_m != 3'b111);
  end

  // funct3[1:0] is log2 of the access size for every legal encoding.
  always_comb begin
    aligned   = 1'b0;
    size_mask = '0;
    unique case (funct3_m[1:0])
      2'd0: begin aligned = 1'b1;                 size_mask = 8'h01; end
      2'd1: begin aligned = (offset[0] == 1'b0);   size_mask = 8'h03; end
      2'd2: begin aligned = (offset[1:0] == 2'b0); size_mask = 8'h0F; end
      2'd3: begin aligned = (offset == '0);        size_mask = 8'hFF; end
    endcase
  end

  // Misaligned or illegal accesses never reach memory; they retire as a
  // flagged no-write instruction on the next edge.
  assign misaligned = is_mem & ~(legal_f3 & aligned);
  assign mem_go     = is_mem & ~misaligned;

  // -------------------------------------------------------------------------
  // Memory request. Fields are taken straight from the M inputs, which
  // upstream holds steady while stall_m is high, so they stay stable until
  // the transfer. rst_n gates the request so it drops the moment reset is
  // asserted even though the M inputs may still describe a memory op.
  // -------------------------------------------------------------------------
  assign req = rst_n & (((state == S_IDLE) & mem_go) | (state == S_REQ));

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & is_store;
  assign dmem.dmem_addr  = {alu_result_m[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign dmem.dmem_wdata = write_data_m << {offset, 3'b000};
  assign dmem.dmem_wstrb = (req & is_store) ? (size_mask << offset) : '0;

  assign accept     = req & dmem.dmem_ready;
  assign store_done = accept & is_store;
  assign load_done  = (state == S_WAIT_DATA) & dmem.dmem_rvalid;

  // A load is never finished in the cycle its request is accepted; only the
  // rvalid cycle releases it. A store releases upstream in its transfer cycle.
  always_comb begin
    stall_m = 1'b0;
    if (state == S_WAIT_DATA) stall_m = ~dmem.dmem_rvalid;
    else                      stall_m = mem_go & ~store_done;
  end

  // -------------------------------------------------------------------------
  // Load data: bring the addressed byte lane down to bit 0, then extend.
  // -------------------------------------------------------------------------
  assign lane = dmem.dmem_rdata >> {offset, 3'b000};

  always_comb begin
    load_data = '0;
    case (funct3_m)
      3'b000:  load_data = {{(XLEN-8){lane[7]}},   lane[7:0]};
      3'b001:  load_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b010:  load_data = {{(XLEN-32){lane[31]}}, lane[31:0]};
      3'b011:  load_data = lane;
      3'b100:  load_data = {{(XLEN-8){1'b0}},      lane[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}},     lane[15:0]};
      3'b110:  load_data = {{(XLEN-32){1'b0}},     lane[31:0]};
      default: load_data = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (mem_go) begin
          if (dmem.dmem_ready) state_next = is_load ? S_WAIT_DATA : S_IDLE;
          else                 state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (dmem.dmem_ready) state_next = is_load ? S_WAIT_DATA : S_IDLE;
      end
      S_WAIT_DATA: begin
        if (dmem.dmem_rvalid) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  assign state_dbg = state;

  // -------------------------------------------------------------------------
  // W-stage registers. Exactly one instruction retires per completing edge;
  // every other edge is a bubble that clears valid/reg_write and leaves the
  // payload registers as they were.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_w            <= 1'b0;
      alu_result_w       <= '0;
      mem_data_w         <= '0;
      next_instruction_w <= '0;
      result_src_w       <= '0;
      rd_w               <= '0;
      reg_write_w        <= 1'b0;
      misaligned_w       <= 1'b0;
    end else if (load_done) begin
      valid_w            <= 1'b1;
      alu_result_w       <= alu_result_m;
      mem_data_w         <= load_data;
      next_instruction_w <= next_instruction_m;
      result_src_w       <= result_src_m;
      rd_w               <= rd_m;
      reg_write_w        <= reg_write_m;
      misaligned_w       <= 1'b0;
    end else if (store_done) begin
      valid_w            <= 1'b1;
      alu_result_w       <= alu_result_m;
      next_instruction_w <= next_instruction_m;
      result_src_w       <= result_src_m;
      rd_w               <= rd_m;
      reg_write_w        <= 1'b0;
      misaligned_w       <= 1'b0;
    end else if ((state == S_IDLE) && misaligned) begin
      valid_w            <= 1'b1;
      alu_result_w       <= alu_result_m;
      next_instruction_w <= next_instruction_m;
      result_src_w       <= result_src_m;
      rd_w               <= rd_m;
      reg_write_w        <= 1'b0;
      misaligned_w       <= 1'b1;
    end else if ((state == S_IDLE) && is_alu) begin
      valid_w            <= 1'b1;
      alu_result_w       <= alu_result_m;
      next_instruction_w <= next_instruction_m;
      result_src_w       <= result_src_m;
      rd_w               <= rd_m;
      reg_write_w        <= reg_write_m;
      misaligned_w       <= 1'b0;
    end else begin
      valid_w            <= 1'b0;
      reg_write_w        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// ---------------------------------------------------------------------------
// tb_memory_access
//
// Directed scenarios followed by randomized instructions for the memory
// stage. A reference model of the W registers and of the expected request
// fields is kept here, computed byte by byte from the instruction rules.
// ---------------------------------------------------------------------------
module tb_memory_access;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT signals
  logic        valid_m;
  logic [63:0] alu_result_m;
  logic [63:0] write_data_m;
  logic [63:0] next_instruction_m;
  logic [1:0]  result_src_m;
  logic        mem_write_m;
  logic        reg_write_m;
  logic [2:0]  funct3_m;
  logic [4:0]  rd_m;
  logic        stall_m;
  logic        valid_w;
  logic [63:0] alu_result_w;
  logic [63:0] mem_data_w;
  logic [63:0] next_instruction_w;
  logic [1:0]  result_src_w;
  logic [4:0]  rd_w;
  logic        reg_write_w;
  logic        misaligned_w;
  logic [1:0]  state_dbg;

  memory_access_if dmem_bus ();

  memory_access dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .valid_m            (valid_m),
    .alu_result_m       (alu_result_m),
    .write_data_m       (write_data_m),
    .next_instruction_m (next_instruction_m),
    .result_src_m       (result_src_m),
    .mem_write_m        (mem_write_m),
    .reg_write_m        (reg_write_m),
    .funct3_m           (funct3_m),
    .rd_m               (rd_m),
    .stall_m            (stall_m),
    .dmem               (dmem_bus.master),
    .valid_w            (valid_w),
    .alu_result_w       (alu_result_w),
    .mem_data_w         (mem_data_w),
    .next_instruction_w (next_instruction_w),
    .result_src_w       (result_src_w),
    .rd_w               (rd_w),
    .reg_write_w        (reg_write_w),
    .misaligned_w       (misaligned_w),
    .state_dbg          (state_dbg)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_cmp = 0;
  int n_err = 0;

  // expected W-stage contents
  logic        m_valid;
  logic [63:0] m_alu;
  logic [63:0] m_mem;
  logic [63:0] m_nxt;
  logic [1:0]  m_src;
  logic [4:0]  m_rd;
  logic        m_regw;
  logic        m_mis;

  // observations kept for directed follow-up checks
  int          stall_cycles;
  logic [7:0]  last_wstrb;
  logic [63:0] last_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag);
    chk_bit({tag, ".valid_w"},      valid_w,            m_valid);
    chk    ({tag, ".alu_result_w"}, alu_result_w,       m_alu);
    chk    ({tag, ".mem_data_w"},   mem_data_w,         m_mem);
    chk    ({tag, ".next_instr_w"}, next_instruction_w, m_nxt);
    chk    ({tag, ".result_src_w"}, 64'(result_src_w),  64'(m_src));
    chk    ({tag, ".rd_w"},         64'(rd_w),          64'(m_rd));
    chk_bit({tag, ".reg_write_w"},  reg_write_w,        m_regw);
    chk_bit({tag, ".misaligned_w"}, misaligned_w,       m_mis);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_alu = '0; m_mem = '0; m_nxt = '0;
    m_src = '0; m_rd = '0; m_regw = 1'b0; m_mis = 1'b0;
  endtask

  task automatic model_bubble();
    m_valid = 1'b0;
    m_regw  = 1'b0;
  endtask

  // ---------------------------------------------------------------- reference rules
  function automatic logic ref_legal(input logic st, input logic [2:0] f3);
    if (st) return (f3 <= 3'd3);
    return (f3 != 3'd7);
  endfunction

  // Gather the addressed bytes one at a time, then extend.
  function automatic logic [63:0] ref_load(input logic [63:0] data, input int off,
                                           input logic [2:0] f3);
    logic [63:0] v;
    int n;
    n = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = data[8*(off+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] src, input int off);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++)
      if (i >= off) w[8*i +: 8] = src[8*(i-off) +: 8];
    return w;
  endfunction

  function automatic logic [7:0] ref_wstrb(input int off, input logic [2:0] f3);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < (1 << f3[1:0]); i++) s[off+i] = 1'b1;
    return s;
  endfunction

  // ---------------------------------------------------------------- driver
  // Called just after a rising edge. Presents one instruction, plays the
  // memory side with the given delays (rdly = cycles before ready,
  // vdly = cycles in WAIT_DATA before rvalid), checks the request fields and
  // stall every cycle, the bubbles, and the W registers after retirement.
  task automatic run_op(input logic vm, input logic [1:0] src, input logic mw,
                        input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [4:0] rd, input logic rw,
                        input logic [63:0] rdata, input int rdly, input int vdly);
    logic        ld, st, bad;
    int          off, n;
    logic [63:0] nxt;
    nxt = {$urandom, $urandom};
    valid_m = vm; result_src_m = src; mem_write_m = mw; funct3_m = f3;
    alu_result_m = addr; write_data_m = wd; rd_m = rd; reg_write_m = rw;
    next_instruction_m = nxt;
    dmem_bus.dmem_rdata = rdata;
    st  = vm && mw;
    ld  = vm && !mw && (src == 2'd1);
    off = int'(addr[2:0]);
    n   = 1 << f3[1:0];
    bad = (st || ld) && (!ref_legal(st, f3) || (off % n) != 0);
    stall_cycles = 0;

    if ((st || ld) && !bad) begin
      for (int c = 0; c <= rdly; c++) begin
        dmem_bus.dmem_ready  = (c == rdly);
        dmem_bus.dmem_rvalid = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk_bit("req",  dmem_bus.dmem_req, 1'b1);
        chk    ("addr", dmem_bus.dmem_addr, {addr[63:3], 3'b000});
        chk_bit("we",   dmem_bus.dmem_we, st);
        if (st) begin
          chk("wstrb", 64'(dmem_bus.dmem_wstrb), 64'(ref_wstrb(off, f3)));
          chk("wdata", dmem_bus.dmem_wdata, ref_wdata(wd, off));
          last_wstrb = dmem_bus.dmem_wstrb;
          last_wdata = dmem_bus.dmem_wdata;
        end
        chk_bit("stall_req", stall_m, !(st && c == rdly));
        if (stall_m) stall_cycles++;
        @(posedge clk); #1;
        if (!(st && c == rdly)) begin
          model_bubble();
          check_w("bubble_req");
        end
      end
      dmem_bus.dmem_ready = 1'b0;
      if (ld) begin
        for (int c = 0; c <= vdly; c++) begin
          dmem_bus.dmem_rvalid = (c == vdly);
          dmem_bus.dmem_ready  = 1'($urandom_range(0, 1));
          @(negedge clk);
          chk_bit("req_wait",   dmem_bus.dmem_req, 1'b0);
          chk_bit("stall_wait", stall_m, c != vdly);
          if (stall_m) stall_cycles++;
          @(posedge clk); #1;
          if (c != vdly) begin
            model_bubble();
            check_w("bubble_wait");
          end
        end
      end
    end else begin
      dmem_bus.dmem_ready  = 1'($urandom_range(0, 1));
      dmem_bus.dmem_rvalid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_bit("req_none",   dmem_bus.dmem_req, 1'b0);
      chk_bit("stall_none", stall_m, 1'b0);
      if (stall_m) stall_cycles++;
      @(posedge clk); #1;
    end
    dmem_bus.dmem_ready  = 1'b0;
    dmem_bus.dmem_rvalid = 1'b0;

    if (!vm) begin
      model_bubble();
    end else begin
      m_valid = 1'b1;
      m_alu   = addr;
      m_nxt   = nxt;
      m_src   = src;
      m_rd    = rd;
      m_mis   = bad;
      m_regw  = (bad || st) ? 1'b0 : rw;
      if (ld && !bad) m_mem = ref_load(rdata, off, f3);
    end
    check_w("retire");
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  logic [63:0] r_addr;
  logic [2:0]  r_f3;
  logic        r_mw;
  int          r_kind;
  int          r_off;

  initial begin
    rst_n = 1'b0;
    valid_m = 1'b0; alu_result_m = '0; write_data_m = '0; next_instruction_m = '0;
    result_src_m = '0; mem_write_m = 1'b0; reg_write_m = 1'b0; funct3_m = '0; rd_m = '0;
    dmem_bus.dmem_ready = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;
    model_reset();

    // Reset is asynchronous: outputs are cleared before any clock edge.
    #1;
    check_w("reset");
    chk_bit("reset.req",  dmem_bus.dmem_req, 1'b0);
    chk_bit("reset.we",   dmem_bus.dmem_we, 1'b0);
    chk    ("reset.strb", 64'(dmem_bus.dmem_wstrb), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU op
    run_op(1'b1, 2'd0, 1'b0, 3'b000, 64'h1234, 64'h0, 5'd5, 1'b1, 64'h0, 0, 0);
    chk    ("alu.alu_result_w", alu_result_w, 64'h1234);
    chk    ("alu.rd_w", 64'(rd_w), 64'd5);
    chk_bit("alu.valid_w", valid_w, 1'b1);
    chk    ("alu.stall_cycles", 64'(stall_cycles), 64'd0);

    // LB / LBU at 0x1003, ready immediately, rvalid the next cycle
    run_op(1'b1, 2'd1, 1'b0, 3'b000, 64'h1003, 64'h0, 5'd7, 1'b1,
           64'h00000000_80000000, 0, 0);
    chk("lb.mem_data_w", mem_data_w, 64'hFFFFFFFF_FFFFFF80);
    chk("lb.stall_cycles", 64'(stall_cycles), 64'd1);
    run_op(1'b1, 2'd1, 1'b0, 3'b100, 64'h1003, 64'h0, 5'd7, 1'b1,
           64'h00000000_80000000, 0, 0);
    chk("lbu.mem_data_w", mem_data_w, 64'h80);
    chk("lbu.stall_cycles", 64'(stall_cycles), 64'd1);

    // SH at 0x2006 with ready low for three cycles
    run_op(1'b1, 2'd0, 1'b1, 3'b001, 64'h2006, 64'hABCD, 5'd9, 1'b1, 64'h0, 3, 0);
    chk    ("sh.wstrb", 64'(last_wstrb), 64'hC0);
    chk    ("sh.wdata_hi", 64'(last_wdata[63:48]), 64'hABCD);
    chk    ("sh.stall_cycles", 64'(stall_cycles), 64'd3);
    chk_bit("sh.valid_w", valid_w, 1'b1);
    chk_bit("sh.reg_write_w", reg_write_w, 1'b0);

    // Misaligned LW
    run_op(1'b1, 2'd1, 1'b0, 3'b010, 64'h3002, 64'h0, 5'd3, 1'b1, 64'h0, 0, 0);
    chk_bit("lw_mis.misaligned_w", misaligned_w, 1'b1);
    chk_bit("lw_mis.valid_w", valid_w, 1'b1);
    chk_bit("lw_mis.reg_write_w", reg_write_w, 1'b0);

    // LD with slow data: four stall cycles in total
    run_op(1'b1, 2'd1, 1'b0, 3'b011, 64'h4000, 64'h0, 5'd11, 1'b1,
           64'h01234567_89ABCDEF, 0, 3);
    chk("ld.mem_data_w", mem_data_w, 64'h01234567_89ABCDEF);
    chk("ld.result_src_w", 64'(result_src_w), 64'd1);
    chk("ld.stall_cycles", 64'(stall_cycles), 64'd4);

    // Reset while a store request is waiting for ready
    valid_m = 1'b1; result_src_m = 2'd0; mem_write_m = 1'b1; funct3_m = 3'b011;
    alu_result_m = 64'h6000; write_data_m = 64'hDEAD_BEEF; rd_m = 5'd1; reg_write_m = 1'b0;
    dmem_bus.dmem_ready = 1'b0;
    @(negedge clk);
    chk_bit("rst_req.req_before", dmem_bus.dmem_req, 1'b1);
    rst_n = 1'b0; #1;
    chk_bit("rst_req.req", dmem_bus.dmem_req, 1'b0);
    chk_bit("rst_req.we",  dmem_bus.dmem_we, 1'b0);
    chk    ("rst_req.strb", 64'(dmem_bus.dmem_wstrb), 64'h0);
    model_reset();
    check_w("rst_req");
    valid_m = 1'b0; #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check_w("rst_req_after");

    // Reset while a load waits for data; a late rvalid is ignored
    run_op(1'b1, 2'd0, 1'b0, 3'b000, 64'h77, 64'h0, 5'd4, 1'b1, 64'h0, 0, 0);
    valid_m = 1'b1; result_src_m = 2'd1; mem_write_m = 1'b0; funct3_m = 3'b011;
    alu_result_m = 64'h5008; rd_m = 5'd6; reg_write_m = 1'b1;
    dmem_bus.dmem_rdata = 64'h1111_2222_3333_4444;
    dmem_bus.dmem_ready = 1'b1;
    @(negedge clk);
    chk_bit("rst_wait.req_before", dmem_bus.dmem_req, 1'b1);
    @(posedge clk); #1;
    dmem_bus.dmem_ready = 1'b0;
    rst_n = 1'b0; #1;
    chk_bit("rst_wait.req", dmem_bus.dmem_req, 1'b0);
    model_reset();
    check_w("rst_wait");
    valid_m = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    dmem_bus.dmem_rvalid = 1'b1;
    @(negedge clk);
    chk_bit("rst_wait.req_late", dmem_bus.dmem_req, 1'b0);
    @(posedge clk); #1;
    dmem_bus.dmem_rvalid = 1'b0;
    check_w("rst_wait_late_rvalid");

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      r_kind = $urandom_range(0, 4);
      r_addr = {$urandom, $urandom};
      case (r_kind)
        0: run_op(1'b1, ($urandom_range(0, 1) != 0) ? 2'd0 : 2'd2, 1'b0,
                  3'($urandom_range(0, 7)), r_addr, {$urandom, $urandom},
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 64'h0, 0, 0);
        1: begin
          r_f3  = 3'($urandom_range(0, 6));
          r_off = $urandom_range(0, 7) & ~((1 << r_f3[1:0]) - 1);
          r_addr[2:0] = 3'(r_off);
          run_op(1'b1, 2'd1, 1'b0, r_f3, r_addr, 64'h0, 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), {$urandom, $urandom},
                 $urandom_range(0, 3), $urandom_range(0, 3));
        end
        2: begin
          r_f3  = 3'($urandom_range(0, 3));
          r_off = $urandom_range(0, 7) & ~((1 << r_f3[1:0]) - 1);
          r_addr[2:0] = 3'(r_off);
          run_op(1'b1, 2'($urandom_range(0, 2)), 1'b1, r_f3, r_addr, {$urandom, $urandom},
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 64'h0,
                 $urandom_range(0, 3), 0);
        end
        3: run_op(1'b0, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), r_addr, {$urandom, $urandom},
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 64'h0, 0, 0);
        default: begin
          r_mw = 1'($urandom_range(0, 1));
          run_op(1'b1, r_mw ? 2'd0 : 2'd1, r_mw, 3'($urandom_range(0, 7)), r_addr,
                 {$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, $urandom_range(0, 2), $urandom_range(0, 2));
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
